// File: rtl/uart_rx_core_pkg.sv
// Shared UART receive constants: FSM state encodings, sub-slot counts and the bit vote.
// The transmit FSM imports the same package so both halves agree on encodings.
package uart_rx_core_pkg;

  typedef enum logic [2:0] {
    UART_RX_IDLE  = 3'd0,
    UART_RX_START = 3'd1,
    UART_RX_DATA  = 3'd2,
    UART_RX_BIT9  = 3'd3,
    UART_RX_STOP  = 3'd4
  } rx_state_e;

  localparam int unsigned UART_SLOTS_DIV3 = 3;
  localparam int unsigned UART_SLOTS_DIV4 = 4;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_core_sync.sv
// Metastability synchroniser for the asynchronous uart_rx pin plus a falling-edge detector.
// All flops reset to 1 so a reset never manufactures a start edge on an idle line.
module uart_rx_core_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '1;
      r_dly  <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rx_s = r_sync[SYNC_STAGES-1];
  assign o_fall = r_dly & ~r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// Receive half of the UART: sub-slot oversampling, majority vote per bit, frame FSM
// and the pending/framing/overrun flag logic seen by the register layer.
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned BAUD_W      = 16
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_uart_en,
  input  logic [BAUD_W-1:0] i_uart_baud,
  input  logic              i_uart_div_sel,
  input  logic              i_uart_prty_en,
  input  logic              i_baud_tick,
  input  logic              i_uart_rx,
  input  logic              i_rxpnd_clr,
  output logic [7:0]        o_rx_data,
  output logic              o_rx_bit9,
  output logic              o_uart_rxpnd,
  output logic              o_uart_ferr,
  output logic              o_uart_ovf,
  output logic              o_rx_busy
);

  logic              w_rx_s;
  logic              w_fall;
  rx_state_e         r_state;
  rx_state_e         w_state_nxt;
  logic [BAUD_W-1:0] r_tick_cnt;
  logic [1:0]        r_slot_cnt;
  logic [1:0]        r_smp;
  logic [1:0]        w_nslot_m1;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_sr;
  logic              r_bit9;
  logic              w_slot_end;
  logic              w_bit_end;
  logic              w_vote;
  logic              w_load;
  logic              w_pnd_eff;
  logic              w_cnt_clr;
  logic [7:0]        r_rx_data;
  logic              r_rx_bit9;
  logic              r_rxpnd;
  logic              r_ferr;
  logic              r_ovf;

  uart_rx_core_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk  (i_sys_clk),
    .i_rst  (i_sys_rst),
    .i_rx   (i_uart_rx),
    .o_rx_s (w_rx_s),
    .o_fall (w_fall)
  );

  assign w_nslot_m1 = i_uart_div_sel ? 2'(UART_SLOTS_DIV3 - 1) : 2'(UART_SLOTS_DIV4 - 1);
  assign w_slot_end = i_baud_tick & (r_tick_cnt == i_uart_baud) & (r_state != UART_RX_IDLE);
  assign w_bit_end  = w_slot_end & (r_slot_cnt == w_nslot_m1);
  // The last three sub-slots of a bit vote: two held in r_smp, the third is live.
  assign w_vote     = maj3(r_smp[1], r_smp[0], w_rx_s);
  assign w_cnt_clr  = i_sys_rst | ~i_uart_en | (r_state == UART_RX_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    unique case (r_state)
      UART_RX_IDLE: begin
        if (w_fall) w_state_nxt = UART_RX_START;
      end
      UART_RX_START: begin
        if (w_bit_end) w_state_nxt = w_vote ? UART_RX_IDLE : UART_RX_DATA;
      end
      UART_RX_DATA: begin
        if (w_bit_end && (r_bit_cnt == 3'd7)) begin
          w_state_nxt = i_uart_prty_en ? UART_RX_BIT9 : UART_RX_STOP;
        end
      end
      UART_RX_BIT9: begin
        if (w_bit_end) w_state_nxt = UART_RX_STOP;
      end
      UART_RX_STOP: begin
        if (w_bit_end) begin
          w_state_nxt = UART_RX_IDLE;
          w_load      = 1'b1;
        end
      end
      default: w_state_nxt = UART_RX_IDLE;
    endcase
    if (!i_uart_en) begin
      w_state_nxt = UART_RX_IDLE;
      w_load      = 1'b0;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) r_state <= UART_RX_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_ff @(posedge i_sys_clk) begin
    if (w_cnt_clr) begin
      r_tick_cnt <= '0;
      r_slot_cnt <= '0;
      r_bit_cnt  <= '0;
      r_smp      <= '0;
    end else begin
      if (i_baud_tick) r_tick_cnt <= w_slot_end ? '0 : r_tick_cnt + BAUD_W'(1);
      if (w_slot_end) begin
        r_smp      <= {r_smp[0], w_rx_s};
        r_slot_cnt <= w_bit_end ? 2'd0 : r_slot_cnt + 2'd1;
      end
      if (w_bit_end && (r_state == UART_RX_DATA)) r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_sr   <= '0;
      r_bit9 <= 1'b0;
    end else if (w_bit_end) begin
      if (r_state == UART_RX_DATA) r_sr   <= {w_vote, r_sr[7:1]};
      if (r_state == UART_RX_BIT9) r_bit9 <= w_vote;
    end
  end

  // A clear arriving with a load is applied first, so that load is not an overrun.
  assign w_pnd_eff = r_rxpnd & ~i_rxpnd_clr;

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_rx_data <= '0;
      r_rx_bit9 <= 1'b0;
      r_rxpnd   <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (i_rxpnd_clr) begin
        r_rxpnd <= 1'b0;
        r_ovf   <= 1'b0;
      end
      if (w_load) begin
        if (!w_pnd_eff) begin
          r_rx_data <= r_sr;
          r_rx_bit9 <= i_uart_prty_en & r_bit9;
          r_ferr    <= ~w_vote;
          r_rxpnd   <= 1'b1;
        end else begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign o_rx_data    = r_rx_data;
  assign o_rx_bit9    = r_rx_bit9;
  assign o_uart_rxpnd = r_rxpnd;
  assign o_uart_ferr  = r_ferr;
  assign o_uart_ovf   = r_ovf;
  assign o_rx_busy    = (r_state != UART_RX_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed frame-level bench for uart_rx_core: a frame-timing model checked every cycle,
// plus literal expectations for each scenario.
`timescale 1ns/1ps
module tb_uart_rx_core;

  localparam int unsigned BAUD_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic [BAUD_W-1:0] baud = '0;
  logic              div_sel = 1'b0;
  logic              prty_en = 1'b0;
  logic              tick = 1'b1;
  logic              rx = 1'b1;
  logic              clr = 1'b0;
  logic [7:0]        rx_data;
  logic              rx_bit9, rxpnd, ferr, ovf, busy;

  uart_rx_core #(
    .SYNC_STAGES (2),
    .BAUD_W      (BAUD_W)
  ) dut (
    .i_sys_clk      (clk),
    .i_sys_rst      (rst),
    .i_uart_en      (en),
    .i_uart_baud    (baud),
    .i_uart_div_sel (div_sel),
    .i_uart_prty_en (prty_en),
    .i_baud_tick    (tick),
    .i_uart_rx      (rx),
    .i_rxpnd_clr    (clr),
    .o_rx_data      (rx_data),
    .o_rx_bit9      (rx_bit9),
    .o_uart_rxpnd   (rxpnd),
    .o_uart_ferr    (ferr),
    .o_uart_ovf     (ovf),
    .o_rx_busy      (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Frame request from the stimulus side (single writer: the initial block).
  int         req_seq = 0;
  int         ld_cyc = 0;
  logic [7:0] ld_data = '0;
  logic       ld_bit9 = 1'b0;
  logic       ld_ferr = 1'b0;
  int         bstart = 0;
  int         bend = 0;
  int         frame_k = 0;

  // Model state (single writer: the model process).
  int         done_seq = 0;
  int         cut_cyc = -1;
  logic [7:0] m_data = '0;
  logic       m_bit9 = 1'b0, m_pnd = 1'b0, m_ferr = 1'b0, m_ovf = 1'b0;
  logic       m_busy;
  int         pnd_rise = -1;
  logic       prev_pnd = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: loads land (3 + bits*NSLOT*(baud+1)) cycles after the line falls.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst || !en) begin
      cut_cyc  = cyc;
      done_seq = req_seq;
    end
    if (rst) begin
      m_data = '0; m_bit9 = 1'b0; m_pnd = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    end else begin
      if (clr) begin
        m_pnd = 1'b0;
        m_ovf = 1'b0;
      end
      if ((done_seq != req_seq) && (cyc == ld_cyc)) begin
        done_seq = req_seq;
        if (!m_pnd) begin
          m_data = ld_data; m_bit9 = ld_bit9; m_ferr = ld_ferr; m_pnd = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    m_busy = (cyc >= bstart) && (cyc < bend) && !(cut_cyc >= bstart);
    #1;
    chk("rx_data", 32'(rx_data), 32'(m_data));
    chk("rx_bit9", 32'(rx_bit9), 32'(m_bit9));
    chk("uart_rxpnd", 32'(rxpnd), 32'(m_pnd));
    chk("uart_ferr", 32'(ferr), 32'(m_ferr));
    chk("uart_ovf", 32'(ovf), 32'(m_ovf));
    chk("rx_busy", 32'(busy), 32'(m_busy));
    if (rxpnd === 1'b1 && prev_pnd !== 1'b1) pnd_rise = cyc;
    prev_pnd = rxpnd;
  end

  // Sends nfull complete bits; a short frame then holds the next bit for extra cycles.
  task automatic send_frame(input logic [7:0] d, input logic b9, input logic stop,
                            input int nfull, input int extra);
    logic [10:0] bits;
    int nb, cpb;
    cpb  = (div_sel ? 3 : 4) * (int'(baud) + 1);
    nb   = prty_en ? 11 : 10;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (prty_en) begin
      bits[9]  = b9;
      bits[10] = stop;
    end else begin
      bits[9] = stop;
    end
    @(negedge clk);
    frame_k = cyc;
    bstart  = cyc + 3;
    bend    = cyc + 3 + nb * cpb;
    ld_cyc  = bend;
    ld_data = d;
    ld_bit9 = prty_en & b9;
    ld_ferr = ~stop;
    req_seq = req_seq + 1;
    for (int i = 0; i < nb && i < nfull; i++) begin
      rx = bits[i];
      repeat (cpb) @(negedge clk);
    end
    if (nfull < nb) begin
      rx = bits[nfull];
      repeat (extra) @(negedge clk);
    end else begin
      rx = 1'b1;
      repeat (2 * cpb) @(negedge clk);
    end
  endtask

  task automatic set_cfg(input logic [BAUD_W-1:0] b, input logic ds, input logic pe);
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    baud = b; div_sel = ds; prty_en = pe;
    @(negedge clk);
    en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int g;
    repeat (4) @(negedge clk);
    chk("reset rx_data", 32'(rx_data), 32'h0);
    chk("reset rxpnd", 32'(rxpnd), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    rst = 1'b0;
    en  = 1'b1;
    repeat (3) @(negedge clk);

    // T1: 4 cycles per bit, 0xA5
    send_frame(8'hA5, 1'b0, 1'b1, 99, 0);
    chk("T1 rx_data", 32'(rx_data), 32'hA5);
    chk("T1 rxpnd", 32'(rxpnd), 32'h1);
    chk("T1 ferr", 32'(ferr), 32'h0);
    chk("T1 latency", 32'(pnd_rise - frame_k), 32'd43);
    pulse_clr();
    chk("T1 clr", 32'(rxpnd), 32'h0);

    // T2: 9 cycles per bit, 9th bit set
    set_cfg(16'd2, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1, 99, 0);
    chk("T2 rx_data", 32'(rx_data), 32'h3C);
    chk("T2 rx_bit9", 32'(rx_bit9), 32'h1);
    chk("T2 latency", 32'(pnd_rise - frame_k), 32'd102);
    pulse_clr();

    // T3: 3-cycle low glitch is a false start
    set_cfg(16'd0, 1'b0, 1'b0);
    @(negedge clk);
    bstart = cyc + 3;
    bend   = cyc + 7;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    chk("T3 busy during", 32'(busy), 32'h1);
    repeat (12) @(negedge clk);
    chk("T3 busy after", 32'(busy), 32'h0);
    chk("T3 rxpnd", 32'(rxpnd), 32'h0);

    // T4: stop bit low
    send_frame(8'h55, 1'b0, 1'b0, 99, 0);
    chk("T4 rx_data", 32'(rx_data), 32'h55);
    chk("T4 ferr", 32'(ferr), 32'h1);
    chk("T4 rxpnd", 32'(rxpnd), 32'h1);
    pulse_clr();

    // T5: overrun, then clear coinciding with a load
    send_frame(8'h11, 1'b0, 1'b1, 99, 0);
    send_frame(8'h22, 1'b0, 1'b1, 99, 0);
    chk("T5 rx_data kept", 32'(rx_data), 32'h11);
    chk("T5 ferr cleared", 32'(ferr), 32'h0);
    chk("T5 ovf", 32'(ovf), 32'h1);
    pulse_clr();
    chk("T5 clr rxpnd", 32'(rxpnd), 32'h0);
    chk("T5 clr ovf", 32'(ovf), 32'h0);
    send_frame(8'h33, 1'b0, 1'b1, 99, 0);
    fork
      send_frame(8'h22, 1'b0, 1'b1, 99, 0);
      begin
        repeat (3) @(negedge clk);
        g = 0;
        while (cyc != ld_cyc - 1 && g < 3000) begin
          @(negedge clk);
          g++;
        end
        if (g >= 3000) chk("T5 clr alignment timeout", 32'(g), 32'd0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
      end
    join
    chk("T5 load on clr data", 32'(rx_data), 32'h22);
    chk("T5 load on clr ovf", 32'(ovf), 32'h0);
    chk("T5 load on clr rxpnd", 32'(rxpnd), 32'h1);

    // T6a: uart_en dropped in data bit 3
    send_frame(8'h5A, 1'b0, 1'b1, 4, 2);
    en = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    chk("T6 en busy", 32'(busy), 32'h0);
    repeat (20) @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("T6 en data held", 32'(rx_data), 32'h22);
    chk("T6 en rxpnd held", 32'(rxpnd), 32'h1);

    // T6b: reset mid-frame
    send_frame(8'hC3, 1'b0, 1'b1, 2, 2);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("T6 rst rx_data", 32'(rx_data), 32'h0);
    chk("T6 rst rxpnd", 32'(rxpnd), 32'h0);
    chk("T6 rst ovf", 32'(ovf), 32'h0);
    chk("T6 rst busy", 32'(busy), 32'h0);
    send_frame(8'h96, 1'b0, 1'b1, 99, 0);
    chk("T6 recover data", 32'(rx_data), 32'h96);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
